// File: rtl/uart_rx_fsm.sv
// UART receiver: 8 data bits LSB first, one parity bit, one stop bit.
// Mid-bit sampling from a 2-FF synchronised line; held byte with valid/error flags.
module uart_rx_fsm #(
  parameter int CLKS_PER_BIT = 5208,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  input  logic       rx_clear,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       framing_err,
  output logic       overrun_err,
  output logic       rx_busy,
  output logic [2:0] rx_state_out
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_START_BIT  = 3'd1,
    S_RX_DATA    = 3'd2,
    S_PARITY_BIT = 3'd3,
    S_STOP_BIT   = 3'd4,
    S_RX_DONE    = 3'd5
  } state_t;

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] L_HALF_M1 = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] L_FULL_M1 = TW'(CLKS_PER_BIT - 1);

  state_t        r_state;
  state_t        w_state_next;
  logic          r_sync1;
  logic          r_rxs;
  logic [TW-1:0] r_timer;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic          r_perr;
  logic          r_ferr;
  logic [7:0]    r_rx_data;
  logic          r_rx_valid;
  logic          r_parity_err;
  logic          r_framing_err;
  logic          r_overrun_err;
  logic          w_sample;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_rxs   <= 1'b1;
    end else begin
      r_sync1 <= rx_in;
      r_rxs   <= r_sync1;
    end
  end

  // Start bit is checked at its midpoint; every later bit one full period after the previous sample.
  assign w_sample = (r_state == S_START_BIT) ? (r_timer == L_HALF_M1)
                                             : (r_timer == L_FULL_M1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_timer <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_state_next != r_state || w_sample) r_timer <= '0;
      else                                     r_timer <= r_timer + 1'b1;
    end
  end

  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:       if (!r_rxs) w_state_next = S_START_BIT;
      S_START_BIT:  if (w_sample) w_state_next = r_rxs ? S_IDLE : S_RX_DATA;
      S_RX_DATA:    if (w_sample && r_bit_cnt == 3'd7) w_state_next = S_PARITY_BIT;
      S_PARITY_BIT: if (w_sample) w_state_next = S_STOP_BIT;
      S_STOP_BIT:   if (w_sample) w_state_next = S_RX_DONE;
      S_RX_DONE:    w_state_next = S_IDLE;
      default:      w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bit_cnt     <= '0;
      r_shift       <= '0;
      r_perr        <= 1'b0;
      r_ferr        <= 1'b0;
      r_rx_data     <= '0;
      r_rx_valid    <= 1'b0;
      r_parity_err  <= 1'b0;
      r_framing_err <= 1'b0;
      r_overrun_err <= 1'b0;
    end else begin
      case (r_state)
        S_RX_DATA: if (w_sample) begin
          r_shift   <= {r_rxs, r_shift[7:1]};
          r_bit_cnt <= r_bit_cnt + 1'b1;  // wraps to 0 on the eighth bit
        end
        S_PARITY_BIT: if (w_sample) r_perr <= (^r_shift) ^ r_rxs ^ PARITY_ODD;
        S_STOP_BIT:   if (w_sample) r_ferr <= ~r_rxs;
        S_RX_DONE: begin
          r_rx_data     <= r_shift;
          r_parity_err  <= r_perr;
          r_framing_err <= r_ferr;
          r_rx_valid    <= 1'b1;
          // A read acknowledged in the same cycle consumes the old byte, so no overrun.
          r_overrun_err <= rx_clear ? 1'b0 : (r_overrun_err | r_rx_valid);
        end
        default: ;
      endcase
      if (rx_clear && r_state != S_RX_DONE) begin
        r_rx_valid    <= 1'b0;
        r_overrun_err <= 1'b0;
      end
    end
  end

  assign rx_data      = r_rx_data;
  assign rx_valid     = r_rx_valid;
  assign parity_err   = r_parity_err;
  assign framing_err  = r_framing_err;
  assign overrun_err  = r_overrun_err;
  assign rx_busy      = (r_state != S_IDLE);
  assign rx_state_out = r_state;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Self-checking bench for uart_rx_fsm: even- and odd-parity instances share one serial line.
module tb_uart_rx_fsm;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;
  localparam int LAT  = 2 + HALF + 10 * CPB + 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_in;
  logic       rx_clear;
  logic [7:0] e_data,  o_data;
  logic       e_valid, o_valid;
  logic       e_perr,  o_perr;
  logic       e_ferr,  o_ferr;
  logic       e_ovr,   o_ovr;
  logic       e_busy,  o_busy;
  logic [2:0] e_state, o_state;

  uart_rx_fsm #(.CLKS_PER_BIT(CPB), .PARITY_ODD(1'b0)) dut_e (
    .clk(clk), .rst(rst), .rx_in(rx_in), .rx_clear(rx_clear),
    .rx_data(e_data), .rx_valid(e_valid), .parity_err(e_perr), .framing_err(e_ferr),
    .overrun_err(e_ovr), .rx_busy(e_busy), .rx_state_out(e_state)
  );

  uart_rx_fsm #(.CLKS_PER_BIT(CPB), .PARITY_ODD(1'b1)) dut_o (
    .clk(clk), .rst(rst), .rx_in(rx_in), .rx_clear(rx_clear),
    .rx_data(o_data), .rx_valid(o_valid), .parity_err(o_perr), .framing_err(o_ferr),
    .overrun_err(o_ovr), .rx_busy(o_busy), .rx_state_out(o_state)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Frame-level reference model of the consumer-visible registers.
  logic [7:0] m_data;
  logic       m_valid, m_perr_e, m_perr_o, m_ferr, m_ovr;

  typedef struct {
    logic [7:0] data;
    logic       pbit;
    logic       stop;
    logic       exp_perr_e;
    logic       exp_perr_o;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_data = 8'h00; m_valid = 1'b0; m_perr_e = 1'b0; m_perr_o = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
  endtask

  task automatic model_frame(input logic [7:0] d, input logic p, input logic s, input bit clr_done);
    m_ovr    = clr_done ? 1'b0 : (m_ovr | m_valid);
    m_valid  = 1'b1;
    m_data   = d;
    m_perr_e = (^d) ^ p;          // even: total count of ones incl. parity must be even
    m_perr_o = ~((^d) ^ p);
    m_ferr   = ~s;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".data"},   e_data,  m_data);
    check({tag, ".valid"},  e_valid, m_valid);
    check({tag, ".perr_e"}, e_perr,  m_perr_e);
    check({tag, ".perr_o"}, o_perr,  m_perr_o);
    check({tag, ".ferr"},   e_ferr,  m_ferr);
    check({tag, ".ovr"},    e_ovr,   m_ovr);
    check({tag, ".busy"},   e_busy,  1'b0);
    check({tag, ".state"},  e_state, 3'd0);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                            input bit clr_done, output int lat);
    logic [10:0] bits;
    int          cyc;
    bits = {s, p, d, 1'b0};
    cyc  = 0;
    lat  = -1;
    for (int b = 0; b < 11; b++) begin
      rx_in = bits[b];
      for (int c = 0; c < CPB; c++) begin
        @(negedge clk);
        cyc++;
        if (lat < 0 && e_valid === 1'b1) lat = cyc;
        rx_clear = clr_done && (e_state === 3'd5);
      end
    end
    rx_clear = 1'b0;
    rx_in    = 1'b1;
    if (!s) repeat (CPB) @(negedge clk);
    model_frame(d, p, s, clr_done);
  endtask

  task automatic pulse_clear();
    rx_clear = 1'b1;
    @(negedge clk);
    rx_clear = 1'b0;
    m_valid  = 1'b0;
    m_ovr    = 1'b0;
  endtask

  initial begin
    logic [7:0]  d;
    logic        p, s;
    bit          cd;
    int          lat;
    logic [10:0] bits;

    vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[3] = '{8'h55, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{8'h80, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

    rst = 1'b1; rx_in = 1'b1; rx_clear = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all("reset");
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Directed frames from the table; the first one also measures start-edge-to-valid latency.
    for (int i = 0; i < 6; i++) begin
      send_frame(vecs[i].data, vecs[i].pbit, vecs[i].stop, 1'b0, lat);
      if (i == 0) check("latency", (lat >= LAT - 1) && (lat <= LAT + 1), 1'b1);
      check($sformatf("vec%0d.data", i),   e_data,  vecs[i].data);
      check($sformatf("vec%0d.valid", i),  e_valid, 1'b1);
      check($sformatf("vec%0d.perr_e", i), e_perr,  vecs[i].exp_perr_e);
      check($sformatf("vec%0d.perr_o", i), o_perr,  vecs[i].exp_perr_o);
      check($sformatf("vec%0d.ferr", i),   e_ferr,  vecs[i].exp_ferr);
      check_all($sformatf("vec%0d", i));
      pulse_clear();
      check_all($sformatf("vec%0d_clr", i));
    end

    // Short low glitch: false start returns to IDLE without touching outputs.
    rx_in = 1'b0;
    repeat (3) @(negedge clk);
    check("glitch.in_start", e_state, 3'd1);
    @(negedge clk);
    rx_in = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check_all("glitch");

    // Overrun, explicit clear, then clear coincident with RX_DONE.
    send_frame(8'h11, ^8'h11, 1'b1, 1'b0, lat);
    send_frame(8'h22, ^8'h22, 1'b1, 1'b0, lat);
    check("ovr.flag", e_ovr, 1'b1);
    check_all("ovr");
    pulse_clear();
    check_all("ovr_clr");
    send_frame(8'h11, ^8'h11, 1'b1, 1'b0, lat);
    send_frame(8'h22, ^8'h22, 1'b1, 1'b0, lat);
    check_all("ovr2");
    send_frame(8'h33, ^8'h33, 1'b1, 1'b1, lat);
    check("clr_done.valid", e_valid, 1'b1);
    check("clr_done.ovr", e_ovr, 1'b0);
    check_all("clr_done");
    pulse_clear();

    // Randomised frames against the model.
    for (int i = 0; i < 20; i++) begin
      d  = 8'($urandom);
      p  = 1'($urandom_range(0, 1));
      s  = ($urandom_range(0, 3) != 0);
      cd = ($urandom_range(0, 3) == 0);
      send_frame(d, p, s, cd, lat);
      check_all($sformatf("rnd%0d", i));
      if ($urandom_range(0, 1) == 1) begin
        pulse_clear();
        check_all($sformatf("rnd%0d_clr", i));
      end
    end

    // Reset in the middle of data bit 4 aborts the frame at once.
    send_frame(8'h5A, ^8'h5A, 1'b1, 1'b0, lat);
    check_all("pre_rst");
    bits = {1'b1, ^8'hC3, 8'hC3, 1'b0};
    for (int b = 0; b < 5; b++) begin
      rx_in = bits[b];
      repeat (CPB) @(negedge clk);
    end
    rx_in = bits[5];
    repeat (HALF) @(negedge clk);
    check("rst.in_data", e_state, 3'd2);
    rst = 1'b1;
    #1;
    model_reset();
    check_all("rst_mid");
    @(negedge clk);
    rx_in = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (CPB) @(negedge clk);
    check_all("after_rst");
    send_frame(8'hC3, ^8'hC3, 1'b1, 1'b0, lat);
    check("c3.latency", (lat >= LAT - 1) && (lat <= LAT + 1), 1'b1);
    check("c3.data", e_data, 8'hC3);
    check_all("c3");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
